// File: rtl/rv_pc_pkg.sv
// Shared definitions for the RV32I program-counter unit: FSM encodings,
// default vectors and the alignment-mask helper.
package rv_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
    localparam int          DEF_IALIGN    = 4;

    // IALIGN=2 (compressed-capable) only needs bit 0 clear; otherwise bits [1:0].
    function automatic logic [1:0] align_mask_f(input int ialign);
        return (ialign == 2) ? 2'b01 : 2'b11;
    endfunction

    localparam logic [1:0] ALIGN_MASK = align_mask_f(DEF_IALIGN);

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with redirect-target alignment check (purely combinational).
module pc_next_sel
    import rv_pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = DEF_TRAP_VEC,
    parameter int              IALIGN   = DEF_IALIGN
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic            i_stall,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_jmp,
    input  logic [XLEN-1:0] i_jmp_target,
    input  logic            i_trap,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_epc_in,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_target,
    output logic            o_retire
);

    localparam logic [1:0] MASK = align_mask_f(IALIGN);

    logic            w_redirect;
    logic [XLEN-1:0] w_target;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = '0;
        o_next_pc  = i_pc_plus4;
        o_misalign = 1'b0;
        o_retire   = 1'b1;

        if (i_trap) begin
            o_next_pc = TRAP_VEC;
            o_retire  = 1'b0;
        end else if (i_mret) begin
            w_redirect = 1'b1;
            w_target   = i_epc_in;
        end else if (i_jmp) begin
            w_redirect = 1'b1;
            w_target   = i_jmp_target;
        end else if (i_br_taken) begin
            w_redirect = 1'b1;
            w_target   = i_br_target;
        end else if (i_stall) begin
            o_next_pc = i_pc;
            o_retire  = 1'b0;
        end

        // A misaligned redirect behaves like a trap: vector away, no retire.
        if (w_redirect) begin
            if ((w_target[1:0] & MASK) != 2'b00) begin
                o_next_pc  = TRAP_VEC;
                o_misalign = 1'b1;
                o_retire   = 1'b0;
            end else begin
                o_next_pc = w_target;
            end
        end
    end

    assign o_target = w_target;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch-address register, BOOT/RUN/HALT control FSM,
// misalignment reporting and retired-instruction counter.
module pc_unit
    import rv_pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [XLEN-1:0] TRAP_VEC  = DEF_TRAP_VEC,
    parameter int              IALIGN    = DEF_IALIGN,
    parameter int              CNT_W     = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_br_taken,
    input  logic [XLEN-1:0]  i_br_target,
    input  logic             i_jmp,
    input  logic [XLEN-1:0]  i_jmp_target,
    input  logic             i_trap,
    input  logic             i_mret,
    input  logic [XLEN-1:0]  i_epc_in,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_pc_plus4,
    output logic             o_fetch_valid,
    output logic             o_misalign_exc,
    output logic [XLEN-1:0]  o_misalign_addr,
    output logic [CNT_W-1:0] o_retired_cnt,
    output logic [1:0]       o_state
);

    pc_state_e        r_state;
    pc_state_e        w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mexc;
    logic [XLEN-1:0]  r_maddr;

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_target;
    logic             w_misalign;
    logic             w_retire;
    logic             w_run;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_run      = (r_state == ST_RUN);

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .IALIGN   (IALIGN)
    ) u_next_sel (
        .i_pc         (r_pc),
        .i_pc_plus4   (w_pc_plus4),
        .i_stall      (i_stall),
        .i_br_taken   (i_br_taken),
        .i_br_target  (i_br_target),
        .i_jmp        (i_jmp),
        .i_jmp_target (i_jmp_target),
        .i_trap       (i_trap),
        .i_mret       (i_mret),
        .i_epc_in     (i_epc_in),
        .o_next_pc    (w_next_pc),
        .o_misalign   (w_misalign),
        .o_target     (w_target),
        .o_retire     (w_retire)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  if (i_halt_req) w_state_next = ST_HALT;
            ST_HALT: if (i_resume)   w_state_next = ST_RUN;
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only RUN cycles update pc/counter; the halt-entry cycle still does.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc    <= RESET_VEC;
            r_cnt   <= '0;
            r_mexc  <= 1'b0;
            r_maddr <= '0;
        end else begin
            r_mexc <= 1'b0;
            if (w_run) begin
                r_pc   <= w_next_pc;
                r_mexc <= w_misalign;
                if (w_retire) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_misalign) begin
                    r_maddr <= w_target;
                end
            end
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_plus4      = w_pc_plus4;
    assign o_fetch_valid   = w_run;
    assign o_misalign_exc  = r_mexc;
    assign o_misalign_addr = r_maddr;
    assign o_retired_cnt   = r_cnt;
    assign o_state         = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: two instances (IALIGN=4 and IALIGN=2) share
// stimulus; a behavioural model pushes expected outputs, a monitor compares.
module tb_pc_unit;

    localparam int EW = 164;
    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] TRP_VEC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        stall, br_taken, jmp, trap, mret, halt_req, resume;
    logic [31:0] br_target, jmp_target, epc_in;

    logic [31:0] a_pc, a_pp4, a_maddr, b_pc, b_pp4, b_maddr;
    logic        a_fv, a_mexc, b_fv, b_mexc;
    logic [63:0] a_cnt, b_cnt;
    logic [1:0]  a_st, b_st;

    pc_unit #(.IALIGN(4)) u_dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_stall(stall),
        .i_br_taken(br_taken), .i_br_target(br_target),
        .i_jmp(jmp), .i_jmp_target(jmp_target),
        .i_trap(trap), .i_mret(mret), .i_epc_in(epc_in),
        .i_halt_req(halt_req), .i_resume(resume),
        .o_pc(a_pc), .o_pc_plus4(a_pp4), .o_fetch_valid(a_fv),
        .o_misalign_exc(a_mexc), .o_misalign_addr(a_maddr),
        .o_retired_cnt(a_cnt), .o_state(a_st)
    );

    pc_unit #(.IALIGN(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_stall(stall),
        .i_br_taken(br_taken), .i_br_target(br_target),
        .i_jmp(jmp), .i_jmp_target(jmp_target),
        .i_trap(trap), .i_mret(mret), .i_epc_in(epc_in),
        .i_halt_req(halt_req), .i_resume(resume),
        .o_pc(b_pc), .o_pc_plus4(b_pp4), .o_fetch_valid(b_fv),
        .o_misalign_exc(b_mexc), .o_misalign_addr(b_maddr),
        .o_retired_cnt(b_cnt), .o_state(b_st)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q_a[$];
    logic [EW-1:0] exp_q_b[$];

    // reference model: mode 0=BOOT 1=RUN 2=HALT
    logic [31:0] m_pc[2];
    int          m_mode[2];
    logic [63:0] m_cnt[2];
    logic        m_mexc[2];
    logic [31:0] m_maddr[2];
    int          m_ialign[2];

    function automatic logic [EW-1:0] pack_exp(int d);
        logic [31:0] pp4;
        logic        fv;
        pp4 = m_pc[d] + 32'd4;
        fv  = (m_mode[d] == 1);
        return {m_pc[d], pp4, 2'(m_mode[d]), fv, m_mexc[d], m_maddr[d], m_cnt[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d]    = RST_VEC;
            m_mode[d]  = 0;
            m_cnt[d]   = 64'd0;
            m_mexc[d]  = 1'b0;
            m_maddr[d] = 32'd0;
        end
    endtask

    task automatic model_step(int d);
        logic [31:0] tgt;
        bit          has_tgt;
        bit          counts;
        if (m_mode[d] == 0) begin
            m_mode[d] = 1;
            m_mexc[d] = 1'b0;
        end else if (m_mode[d] == 2) begin
            m_mexc[d] = 1'b0;
            if (resume) m_mode[d] = 1;
        end else begin
            m_mexc[d] = 1'b0;
            has_tgt = 0;
            counts  = 1;
            tgt     = 32'd0;
            if (trap) begin
                m_pc[d] = TRP_VEC;
                counts  = 0;
            end else if (mret)     begin tgt = epc_in;     has_tgt = 1; end
            else if (jmp)          begin tgt = jmp_target; has_tgt = 1; end
            else if (br_taken)     begin tgt = br_target;  has_tgt = 1; end
            else if (stall)        counts = 0;
            else                   m_pc[d] = m_pc[d] + 32'd4;
            if (has_tgt) begin
                if ((tgt % m_ialign[d]) != 0) begin
                    m_pc[d]    = TRP_VEC;
                    m_mexc[d]  = 1'b1;
                    m_maddr[d] = tgt;
                    counts     = 0;
                end else begin
                    m_pc[d] = tgt;
                end
            end
            if (counts) m_cnt[d] = m_cnt[d] + 64'd1;
            if (halt_req) m_mode[d] = 2;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input logic [EW-1:0] e,
                             input logic [31:0] pc, input logic [31:0] pp4,
                             input logic [1:0] st, input logic fv, input logic mexc,
                             input logic [31:0] maddr, input logic [63:0] cnt);
        chk({tag, ".pc"},            64'(pc),    64'(e[163:132]));
        chk({tag, ".pc_plus4"},      64'(pp4),   64'(e[131:100]));
        chk({tag, ".state"},         64'(st),    64'(e[99:98]));
        chk({tag, ".fetch_valid"},   64'(fv),    64'(e[97]));
        chk({tag, ".misalign_exc"},  64'(mexc),  64'(e[96]));
        chk({tag, ".misalign_addr"}, 64'(maddr), 64'(e[95:64]));
        chk({tag, ".retired_cnt"},   cnt,        e[63:0]);
    endtask

    // monitor: compares whenever an expectation is pending after a clock edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_a.size() > 0) check_dut("a", exp_q_a.pop_front(), a_pc, a_pp4, a_st, a_fv, a_mexc, a_maddr, a_cnt);
            if (exp_q_b.size() > 0) check_dut("b", exp_q_b.pop_front(), b_pc, b_pp4, b_st, b_fv, b_mexc, b_maddr, b_cnt);
        end
    end

    // driver: apply one cycle of inputs, advance the model, queue expectation
    task automatic drive(input logic s, input logic br, input logic [31:0] brt,
                         input logic j, input logic [31:0] jt, input logic tr,
                         input logic mr, input logic [31:0] epc,
                         input logic hr, input logic rs);
        stall = s; br_taken = br; br_target = brt; jmp = j; jmp_target = jt;
        trap = tr; mret = mr; epc_in = epc; halt_req = hr; resume = rs;
        for (int d = 0; d < 2; d++) model_step(d);
        exp_q_a.push_back(pack_exp(0));
        exp_q_b.push_back(pack_exp(1));
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_inputs();
        stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_target = 0;
        trap = 0; mret = 0; epc_in = 0; halt_req = 0; resume = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".a.pc"},   64'(a_pc), 64'(RST_VEC));
        chk({tag, ".a.state"}, 64'(a_st), 64'd0);
        chk({tag, ".a.cnt"},  a_cnt, 64'd0);
        chk({tag, ".a.fv"},   64'(a_fv), 64'd0);
        chk({tag, ".a.mexc"}, 64'(a_mexc), 64'd0);
        chk({tag, ".a.maddr"}, 64'(a_maddr), 64'd0);
        chk({tag, ".b.pc"},   64'(b_pc), 64'(RST_VEC));
        chk({tag, ".b.state"}, 64'(b_st), 64'd0);
        chk({tag, ".b.cnt"},  b_cnt, 64'd0);
    endtask

    // async reset asserted mid-cycle; called right after a negedge
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_reset_values("async_rst");
        exp_q_a.delete();
        exp_q_b.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_after_rst.state", 64'(a_st), 64'd0);
        chk("boot_after_rst.pc", 64'(a_pc), 64'(RST_VEC));
    endtask

    initial begin
        logic [31:0] t1, t2, t3;
        m_ialign[0] = 4;
        m_ialign[1] = 2;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        check_reset_values("por");
        #8;
        rst_n = 1'b1;
        #1;
        chk("boot.state", 64'(a_st), 64'd0);
        chk("boot.fv", 64'(a_fv), 64'd0);

        // free run: BOOT->RUN at pc 0, then 4, 8
        idle(); idle(); idle();
        // stall holds, redirect overrides stall
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        // trap beats jump, then mret
        drive(0, 0, 0, 1, 32'h80, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
        // misaligned jump (only for IALIGN=4), pulse then clear
        drive(0, 0, 0, 1, 32'h82, 0, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 1, 32'h81, 0, 0, 0, 0, 0);
        idle();
        // halt at 0x10, branch ignored, resume wins over halt_req
        drive(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 32'h40, 1, 32'h80, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        // pc+4 wraps
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        async_reset();
        // controls during BOOT are ignored
        drive(1, 1, 32'h40, 1, 32'h80, 1, 1, 32'h44, 1, 0);
        idle();

        // randomized run
        for (int i = 0; i < 600; i++) begin
            t1 = $urandom; t2 = $urandom; t3 = $urandom;
            if ($urandom_range(0, 3) != 0) t1[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) t2[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) t3[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, t1,
                  $urandom_range(0, 8) == 0, t2, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, t3,
                  $urandom_range(0, 25) == 0, $urandom_range(0, 4) == 0);
            if (i == 300) async_reset();
        end
        idle();

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q_a.size() + exp_q_b.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
